// File: rtl/gauss_window_ctrl.sv
// ============================================================================
//  Module   : gauss_window_ctrl
//  Function : 4-slot line store feeding 3x3 pixel windows to the convolution
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gauss_window_ctrl #(
  parameter int LINE_WIDTH = 640,
  parameter int PIX_W      = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [PIX_W-1:0]   i_pixel_data,
  input  logic               i_pixel_data_valid,
  input  logic               i_rd_enable,
  output logic [9*PIX_W-1:0] o_window,
  output logic               o_window_valid,
  output logic               o_intr,
  output logic               o_overflow
);

  localparam int COL_W = $clog2(LINE_WIDTH);
  localparam int CNT_W = $clog2(4*LINE_WIDTH+1);
  localparam logic [COL_W-1:0] c_last_col = COL_W'(LINE_WIDTH-1);
  localparam logic [COL_W-1:0] c_first_win = COL_W'(2);
  localparam logic [CNT_W-1:0] c_full  = CNT_W'(4*LINE_WIDTH);
  localparam logic [CNT_W-1:0] c_ready = CNT_W'(3*LINE_WIDTH);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RD = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PIX_W-1:0]   r_mem [4][LINE_WIDTH];
  logic [COL_W-1:0]   r_wr_col;
  logic [1:0]         r_wr_sel;
  logic [COL_W-1:0]   r_rd_col;
  logic [1:0]         r_rd_sel;
  logic [CNT_W-1:0]   r_pix_cnt;
  logic [PIX_W-1:0]   r_c0 [3];
  logic [PIX_W-1:0]   r_c1 [3];
  logic [PIX_W-1:0]   w_col [3];
  logic [9*PIX_W-1:0] w_win;
  logic               w_wr_acc;
  logic               w_wr_drop;
  logic               w_rd;
  logic               w_rd_last;

  assign w_wr_acc  = i_pixel_data_valid && (r_pix_cnt < c_full);
  assign w_wr_drop = i_pixel_data_valid && !w_wr_acc;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // IDLE waits on the registered count, so every line costs at least one idle cycle
  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    w_rd_last   = 1'b0;
    case (r_state)
      ST_IDLE: if (r_pix_cnt >= c_ready) w_state_nxt = ST_RD;
      ST_RD: begin
        if (i_rd_enable) begin
          w_rd = 1'b1;
          if (r_rd_col == c_last_col) begin
            w_rd_last   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Rows are picked by age relative to rd_sel; the 2-bit sum wraps 3->0
  always_comb begin
    w_win = '0;
    for (int r = 0; r < 3; r++) begin
      w_col[r] = r_mem[r_rd_sel + 2'(r)][r_rd_col];
      w_win[PIX_W*(3*r)   +: PIX_W] = r_c0[r];
      w_win[PIX_W*(3*r+1) +: PIX_W] = r_c1[r];
      w_win[PIX_W*(3*r+2) +: PIX_W] = w_col[r];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wr_acc) r_mem[r_wr_sel][r_wr_col] <= i_pixel_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_col       <= '0;
      r_wr_sel       <= '0;
      r_rd_col       <= '0;
      r_rd_sel       <= '0;
      r_pix_cnt      <= '0;
      o_window       <= '0;
      o_window_valid <= 1'b0;
      o_intr         <= 1'b0;
      o_overflow     <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        r_c0[r] <= '0;
        r_c1[r] <= '0;
      end
    end else begin
      if (w_wr_acc) begin
        if (r_wr_col == c_last_col) begin
          r_wr_col <= '0;
          r_wr_sel <= r_wr_sel + 2'd1;
        end else begin
          r_wr_col <= r_wr_col + COL_W'(1);
        end
      end
      if (w_wr_drop) o_overflow <= 1'b1;

      case ({w_wr_acc, w_rd})
        2'b10:   r_pix_cnt <= r_pix_cnt + c_one;
        2'b01:   r_pix_cnt <= r_pix_cnt - c_one;
        default: r_pix_cnt <= r_pix_cnt;
      endcase

      o_intr         <= w_rd_last;
      o_window_valid <= 1'b0;
      if (w_rd) begin
        if (w_rd_last) begin
          r_rd_col <= '0;
          r_rd_sel <= r_rd_sel + 2'd1;
        end else begin
          r_rd_col <= r_rd_col + COL_W'(1);
        end
        for (int r = 0; r < 3; r++) begin
          r_c0[r] <= r_c1[r];
          r_c1[r] <= w_col[r];
        end
        if (r_rd_col >= c_first_win) begin
          o_window       <= w_win;
          o_window_valid <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
